ultrasonido_scheduler: RTL and testbench

Round-robin measurement scheduler for up to N_SENS HC-SR04-style ultrasonic sensors that share one echo-timing datapath. It issues one trigger pulse at a time, times the matching echo in microseconds, enforces an echo timeout and an inter-ping holdoff, then publishes a per-sensor result. It sits between the sensor pins and the consumers of distance data (proximity LEDs, game logic).

---
 rtl/ultrasonido_scheduler_if.sv | 42 ++++
 rtl/ultrasonido_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_ultrasonido_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ultrasonido_scheduler_if.sv
// Pin and result bundle for the ultrasonic measurement scheduler.
// master: scheduler (drives trigger/busy/result/near);
// slave: sensor pins and consumers (drive enable/echo).
// enable: run scan; echo: raw sensor echoes;
// result_*: one-cycle strobe plus held fields; near: sticky flags.
interface ultrasonido_scheduler_if #(
  parameter int N_SENS = 4
);
  logic              enable;
  logic [N_SENS-1:0] echo;
  logic [N_SENS-1:0] trigger;
  logic              busy;
  logic              result_valid;
  logic [2:0]        result_id;
  logic [15:0]       result_us;
  logic              result_timeout;
  logic [N_SENS-1:0] near;

  modport master (
    input  enable,
    input  echo,
    output trigger,
    output busy,
    output result_valid,
    output result_id,
    output result_us,
    output result_timeout,
    output near
  );

  modport slave (
    output enable,
    output echo,
    input  trigger,
    input  busy,
    input  result_valid,
    input  result_id,
    input  result_us,
    input  result_timeout,
    input  near
  );
endinterface

// File: rtl/ultrasonido_scheduler.sv
// Round-robin HC-SR04 scheduler sharing one echo timer.
// Ports: clk; reset_n (async, active-high);
// bus (master): enable, echo in; trigger, busy,
// result_valid/id/us/timeout, near out.
module ultrasonido_scheduler #(
  parameter int N_SENS      = 4,
  parameter int TICK_DIV    = 50,
  parameter int TRIG_CYCLES = 500,
  parameter int TIMEOUT_US  = 30000,
  parameter int GAP_US      = 60000,
  parameter int THRESH_US   = 2900
) (
  input logic clk,
  input logic reset_n,
  ultrasonido_scheduler_if.master bus
);

  localparam int IW = $clog2(N_SENS);

  localparam logic [15:0] TICK_LAST =
    16'(TICK_DIV - 1);
  localparam logic [15:0] TRIG_LAST =
    16'(TRIG_CYCLES - 1);
  localparam logic [15:0] TIMEOUT =
    16'(TIMEOUT_US);
  localparam logic [15:0] GAP =
    16'(GAP_US);
  localparam logic [15:0] THRESH =
    16'(THRESH_US);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(N_SENS - 1);
  localparam logic [N_SENS-1:0] ONE =
    {{(N_SENS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       presc_q, presc_d;
  logic [15:0]       us_q, us_d;
  logic [15:0]       trig_cnt_q, trig_cnt_d;
  logic [N_SENS-1:0] sync1_q, sync1_d;
  logic [N_SENS-1:0] sync2_q, sync2_d;
  logic [N_SENS-1:0] trigger_q, trigger_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic [2:0]        rid_q, rid_d;
  logic [15:0]       rus_q, rus_d;
  logic              rto_q, rto_d;
  logic [N_SENS-1:0] near_q, near_d;

  logic              tick;
  logic              echo_cur;
  logic              pub;
  logic              pub_to;
  logic [15:0]       pub_us;

  assign tick     = (presc_q == TICK_LAST);
  assign echo_cur = sync2_q[idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    us_d       = us_q;
    trig_cnt_d = trig_cnt_q;
    trigger_d  = trigger_q;
    rv_d       = 1'b0;
    rid_d      = rid_q;
    rus_d      = rus_q;
    rto_d      = rto_q;
    near_d     = near_q;
    pub        = 1'b0;
    pub_to     = 1'b0;
    pub_us     = us_q;
    sync1_d    = bus.echo;
    sync2_d    = sync1_q;
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        trigger_d = '0;
        if (bus.enable) begin
          state_d    = S_TRIG;
          trig_cnt_d = '0;
          trigger_d  = ONE << idx_q;
        end
      end
      S_TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d   = S_WAIT;
          trigger_d = '0;
          presc_d   = '0;
          us_d      = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        // a stuck-high echo is taken as an
        // immediate rise, then times out
        if (echo_cur) begin
          state_d = S_MEAS;
          us_d    = '0;
        end else if (us_q >= TIMEOUT) begin
          pub    = 1'b1;
          pub_to = 1'b1;
          pub_us = TIMEOUT;
        end else if (tick) begin
          us_d = us_q + 16'd1;
        end
      end
      S_MEAS: begin
        if (!echo_cur) begin
          pub = 1'b1;
        end else if (us_q >= TIMEOUT) begin
          pub    = 1'b1;
          pub_to = 1'b1;
          pub_us = TIMEOUT;
        end else if (tick) begin
          us_d = us_q + 16'd1;
        end
      end
      S_GAP: begin
        // enable only matters here, so a
        // measurement always runs to the end
        if (us_q >= GAP) begin
          us_d  = '0;
          idx_d = (idx_q == LAST_IDX) ?
                  '0 : idx_q + 1'b1;
          if (bus.enable) begin
            state_d    = S_TRIG;
            trig_cnt_d = '0;
            trigger_d  = ONE << idx_d;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick) begin
          us_d = us_q + 16'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        trigger_d = '0;
      end
    endcase

    if (pub) begin
      state_d        = S_GAP;
      presc_d        = '0;
      us_d           = '0;
      rv_d           = 1'b1;
      rid_d          = 3'(idx_q);
      rus_d          = pub_us;
      rto_d          = pub_to;
      near_d[idx_q]  = !pub_to &&
                       (pub_us < THRESH);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      presc_q    <= '0;
      us_q       <= '0;
      trig_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      trigger_q  <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      rid_q      <= '0;
      rus_q      <= '0;
      rto_q      <= 1'b0;
      near_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      us_q       <= us_d;
      trig_cnt_q <= trig_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      trigger_q  <= trigger_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      rid_q      <= rid_d;
      rus_q      <= rus_d;
      rto_q      <= rto_d;
      near_q     <= near_d;
    end
  end

  assign bus.trigger        = trigger_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = rv_q;
  assign bus.result_id      = rid_q;
  assign bus.result_us      = rus_q;
  assign bus.result_timeout = rto_q;
  assign bus.near           = near_q;

endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// Directed bench for ultrasonido_scheduler,
// run with scaled-down timing parameters.
module tb_ultrasonido_scheduler;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int TR = 10;
  localparam int TO = 300;
  localparam int GP = 100;
  localparam int TH = 29;

  logic clk;
  logic reset_n;

  ultrasonido_scheduler_if #(.N_SENS(N)) bus();

  ultrasonido_scheduler #(
    .N_SENS     (N),
    .TICK_DIV   (TD),
    .TRIG_CYCLES(TR),
    .TIMEOUT_US (TO),
    .GAP_US     (GP),
    .THRESH_US  (TH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // observers (written only here)
  int          rise_id_q[$];
  int          rise_cyc_q[$];
  int          trig_len   = 0;
  int          last_width = 0;
  int          onehot_err = 0;
  int          res_cnt    = 0;
  int          res_id     = 0;
  int          res_us     = 0;
  int          res_to     = 0;
  int          res_cyc    = 0;
  logic [N-1:0] res_near  = '0;
  logic [N-1:0] prev_trig = '0;

  always @(negedge clk) begin
    if ($countones(bus.trigger) > 1)
      onehot_err++;
    if (bus.trigger != '0 && prev_trig == '0) begin
      trig_len = 1;
      for (int i = 0; i < N; i++)
        if (bus.trigger[i]) rise_id_q.push_back(i);
      rise_cyc_q.push_back(cyc);
    end else if (bus.trigger != '0) begin
      trig_len++;
    end else if (prev_trig != '0) begin
      last_width = trig_len;
    end
    if (bus.result_valid) begin
      res_cnt++;
      res_id   = int'(bus.result_id);
      res_us   = int'(bus.result_us);
      res_to   = int'(bus.result_timeout);
      res_near = bus.near;
      res_cyc  = cyc;
    end
    prev_trig = bus.trigger;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  logic [N-1:0] near_exp = '0;

  // mode 0: echo of w us after dly us
  // mode 1: no echo (rise timeout)
  // mode 2: echo stuck high (width timeout)
  task automatic serve(input int s,
                       input int dly,
                       input int w,
                       input int mode,
                       input bit drop);
    int t;
    int r0;
    int fall_c;
    int obs;
    r0 = res_cnt;
    if (mode == 2) bus.echo[s] = 1'b1;
    t = 0;
    while (bus.trigger[s] !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("trig_seen", 32'(bus.trigger[s]), 1);
    t = 0;
    while (bus.trigger[s] === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    fall_c = cyc;
    if (mode == 0) begin
      repeat (dly * TD) @(negedge clk);
      bus.echo[s] = 1'b1;
      for (int i = 0; i < w * TD; i++) begin
        @(negedge clk);
        if (drop && i == (w * TD) / 2)
          bus.enable = 1'b0;
      end
      bus.echo[s] = 1'b0;
    end else if (mode == 1) begin
      // spurious pulses on other sensors
      repeat (10 * TD) @(negedge clk);
      bus.echo[(s + 1) % N]     = 1'b1;
      bus.echo[(s + N - 1) % N] = 1'b1;
      repeat (10 * TD) @(negedge clk);
      bus.echo[(s + 1) % N]     = 1'b0;
      bus.echo[(s + N - 1) % N] = 1'b0;
    end
    t = 0;
    while (res_cnt == r0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("res_seen", 32'(res_cnt - r0), 1);
    chk("trig_w", 32'(last_width), TR);
    chk("res_id", 32'(res_id), 32'(s));
    if (mode == 0) begin
      obs = (res_us >= w - 1 && res_us <= w + 1) ?
            w : res_us;
      chk("res_us", 32'(obs), 32'(w));
      chk("res_to", 32'(res_to), 0);
      near_exp[s] = (w < TH);
    end else begin
      chk("res_us_to", 32'(res_us), TO);
      chk("res_to", 32'(res_to), 1);
      near_exp[s] = 1'b0;
    end
    if (mode == 1) begin
      obs = res_cyc - fall_c;
      if (obs >= TO * TD - 3 && obs <= TO * TD + 3)
        obs = TO * TD;
      chk("to_latency", 32'(obs), TO * TD);
    end
    chk("near", 32'(res_near), 32'(near_exp));
    if (mode == 2) bus.echo[s] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int base;
  int t;
  int mingap;
  int rc;
  int exp_order[7];

  initial begin
    exp_order = '{0, 1, 2, 3, 0, 1, 2};
    reset_n    = 1'b1;
    bus.enable = 1'b0;
    bus.echo   = '0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(bus.trigger), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rv", 32'(bus.result_valid), 0);
    chk("rst_us", 32'(bus.result_us), 0);
    chk("rst_near", 32'(bus.near), 0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    bus.enable = 1'b1;
    serve(0, 20, 12, 0, 1'b0);

    // reset in the middle of sensor 1 trigger
    t = 0;
    while (bus.trigger[1] !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("trig1_pre_rst", 32'(bus.trigger), 2);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_trig", 32'(bus.trigger), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_id", 32'(bus.result_id), 0);
    chk("mrst_us", 32'(bus.result_us), 0);
    chk("mrst_to", 32'(bus.result_timeout), 0);
    chk("mrst_near", 32'(bus.near), 0);
    near_exp = '0;
    base = rise_id_q.size();
    reset_n = 1'b0;

    serve(0, 20, 12, 0, 1'b0);
    chk("first_after_rst",
        32'(rise_id_q[base]), 0);
    serve(1, 0, 0, 1, 1'b0);
    serve(2, 20, 58, 0, 1'b0);
    serve(3, 0, 0, 2, 1'b0);
    serve(0, 20, 58, 0, 1'b0);
    serve(1, 20, 12, 0, 1'b0);
    serve(2, 20, 12, 0, 1'b1);

    rc = rise_id_q.size();
    t = 0;
    while (bus.busy !== 1'b0 && t < GP * TD + 100) begin
      @(negedge clk);
      t++;
    end
    chk("stop_busy", 32'(bus.busy), 0);
    repeat (300) @(negedge clk);
    chk("no_more_trig",
        32'(rise_id_q.size() - rc), 0);
    chk("stop_trig", 32'(bus.trigger), 0);

    chk("n_rises", 32'(rise_id_q.size() - base), 7);
    for (int i = 0; i < 7; i++)
      if (base + i < rise_id_q.size())
        chk("order", 32'(rise_id_q[base + i]),
            32'(exp_order[i]));
    mingap = 1 << 30;
    for (int i = base + 1; i < rise_cyc_q.size(); i++)
      if (rise_cyc_q[i] - rise_cyc_q[i-1] < mingap)
        mingap = rise_cyc_q[i] - rise_cyc_q[i-1];
    if (mingap >= GP * TD) mingap = GP * TD;
    chk("min_gap", 32'(mingap), GP * TD);
    chk("onehot", 32'(onehot_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
